// File: rtl/inject_ni_buf.sv
// Injection buffer between a stream generator and a router local port.
// Show-ahead FIFO with overflow drop counting and an IDLE/RUN/DRAIN/DONE run controller.
module inject_ni_buf #(
    parameter int DEPTH   = 8,
    parameter int IDLE_TO = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     gen_enable,
    input  logic [19:0]              in_data,
    input  logic                     in_valid,
    output logic [19:0]              flit_out,
    output logic                     flit_valid,
    input  logic                     flit_ready,
    output logic [1:0]               dest_cluster,
    output logic [1:0]               dest_local,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              sent_cnt,
    output logic [7:0]               drop_cnt,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(IDLE_TO + 1);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] GEN_MAX  = (AW+1)'(DEPTH - 2);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TO - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    logic [19:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   occ_q;
    state_t        state_q;
    logic [IW-1:0] idle_q;
    logic [15:0]   sent_q;
    logic [7:0]    drop_q;
    logic          done_q;

    logic pop, push, drop;

    assign pop  = (occ_q != '0) && flit_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push = in_valid && ((occ_q != FULL) || pop);
    assign drop = in_valid && !push;

    // Enable drops one entry early so the generator's in-flight word always fits.
    assign gen_enable   = (state_q == RUN) && (occ_q <= GEN_MAX);
    assign flit_out     = mem_q[rd_ptr_q];
    assign flit_valid   = (occ_q != '0);
    assign dest_cluster = flit_out[3:2];
    assign dest_local   = flit_out[1:0];
    assign occupancy    = occ_q;
    assign sent_cnt     = sent_q;
    assign drop_cnt     = drop_q;
    assign done         = done_q;

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            sent_q   <= '0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                sent_q   <= sent_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + (AW+1)'(1);
                2'b01:   occ_q <= occ_q - (AW+1)'(1);
                default: occ_q <= occ_q;
            endcase
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idle_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= RUN;
                    idle_q  <= '0;
                end
                RUN: begin
                    // Stalled cycles (gen_enable low) leave the idle count untouched.
                    if (in_valid) idle_q <= '0;
                    else if (gen_enable) begin
                        idle_q <= idle_q + IW'(1);
                        if (idle_q == IDLE_LAST) state_q <= DRAIN;
                    end
                end
                DRAIN: if (occ_q == '0) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inject_ni_buf.sv
// Self-checking bench for inject_ni_buf: directed scenarios plus a randomized run,
// all compared every cycle against a queue-based reference model.
module tb_inject_ni_buf;
    localparam int DEPTH   = 8;
    localparam int IDLE_TO = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    logic        clk = 0;
    logic        rst, start, gen_enable, in_valid, flit_valid, flit_ready, done;
    logic [19:0] in_data, flit_out;
    logic [1:0]  dest_cluster, dest_local;
    logic [3:0]  occupancy;
    logic [15:0] sent_cnt;
    logic [7:0]  drop_cnt;

    inject_ni_buf #(.DEPTH(DEPTH), .IDLE_TO(IDLE_TO)) dut (
        .clk(clk), .rst(rst), .start(start), .gen_enable(gen_enable),
        .in_data(in_data), .in_valid(in_valid), .flit_out(flit_out),
        .flit_valid(flit_valid), .flit_ready(flit_ready),
        .dest_cluster(dest_cluster), .dest_local(dest_local),
        .occupancy(occupancy), .sent_cnt(sent_cnt), .drop_cnt(drop_cnt),
        .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue, counters as plain ints.
    logic [19:0] m_q[$];
    int m_sent, m_drop, m_st, m_idle;

    // Stream generator: emits one cycle after it saw gen_enable high.
    logic [19:0] gq[$];
    bit g_armed;
    int g_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int occ = m_q.size();
        logic [19:0] head;
        chk("flit_valid", 32'(flit_valid), 32'(occ != 0));
        chk("occupancy", 32'(occupancy), 32'(occ));
        chk("gen_enable", 32'(gen_enable), 32'(m_st == M_RUN && occ <= DEPTH - 2));
        chk("done", 32'(done), 32'(m_st == M_DONE));
        chk("sent_cnt", 32'(sent_cnt), 32'(m_sent));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (occ != 0) begin
            head = m_q[0];
            chk("flit_out", 32'(flit_out), 32'(head));
            chk("dest_cluster", 32'(dest_cluster), 32'(head[3:2]));
            chk("dest_local", 32'(dest_local), 32'(head[1:0]));
            if (head == 20'h001A3) chk("dest_1A3", 32'({dest_cluster, dest_local}), 32'h3);
            if (head == 20'h00152) chk("dest_152", 32'({dest_cluster, dest_local}), 32'h2);
        end
    endtask

    task automatic model_update(input bit r, input bit s, input bit v, input logic [19:0] d, input bit rdy);
        int occ;
        bit pop, push, gen;
        if (r) begin
            m_q.delete();
            m_sent = 0; m_drop = 0; m_st = M_IDLE; m_idle = 0;
            return;
        end
        occ  = m_q.size();
        pop  = (occ != 0) && rdy;
        push = v && (occ < DEPTH || pop);
        gen  = (m_st == M_RUN) && (occ <= DEPTH - 2);
        case (m_st)
            M_IDLE:  if (s) begin m_st = M_RUN; m_idle = 0; end
            M_RUN:   if (v) m_idle = 0;
                     else if (gen) begin
                         m_idle++;
                         if (m_idle == IDLE_TO) m_st = M_DRAIN;
                     end
            M_DRAIN: if (occ == 0) m_st = M_DONE;
            default: ;
        endcase
        if (pop) begin
            void'(m_q.pop_front());
            m_sent = (m_sent + 1) % 65536;
        end
        if (push) m_q.push_back(d);
        else if (v && m_drop < 255) m_drop++;
    endtask

    // One clock: drive inputs, compare against the model, advance both.
    task automatic step(input bit r, input bit s, input bit v, input logic [19:0] d, input bit rdy);
        rst = r; start = s; in_valid = v; in_data = d; flit_ready = rdy;
        check_outputs();
        @(posedge clk);
        model_update(r, s, v, d, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 20'h0, 0);
        gq.delete();
        g_armed = 0;
        g_idle = 0;
    endtask

    // rmode: 0 never ready, 1 always ready, 2 random.
    task automatic gen_cycle(input bit s, input int rmode, input int skip_pct);
        bit v = 0;
        bit rdy;
        bit nxt;
        logic [19:0] d = 20'($urandom);
        if (g_armed && gq.size() > 0 && !(g_idle < 2 && $urandom_range(99) < skip_pct)) begin
            v = 1;
            d = gq.pop_front();
            g_idle = 0;
        end else g_idle++;
        rdy = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom_range(1));
        nxt = gen_enable;
        step(0, s, v, d, rdy);
        g_armed = nxt;
    endtask

    initial begin
        int k;
        rst = 1; start = 0; in_valid = 0; in_data = '0; flit_ready = 0;
        repeat (2) @(posedge clk);
        model_update(1, 0, 0, 20'h0, 0);
        @(negedge clk);
        g_armed = 0; g_idle = 0;

        // Reset state
        chk("rst_flit_valid", 32'(flit_valid), 0);
        chk("rst_gen_enable", 32'(gen_enable), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_sent", 32'(sent_cnt), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // 30-flit stream with the router always ready
        do_reset();
        for (int i = 0; i < 30; i++)
            gq.push_back((i == 0) ? 20'h00010 : (i == 29) ? 20'h001E3 :
                         20'(((i + 1) << 4) | $urandom_range(15)));
        gen_cycle(1, 1, 30);
        k = 0;
        while (done !== 1'b1 && k < 200) begin gen_cycle(0, 1, 30); k++; end
        chk("stream_done", 32'(done), 1);
        chk("stream_sent", 32'(sent_cnt), 30);
        chk("stream_drop", 32'(drop_cnt), 0);

        // Randomized run with random backpressure
        do_reset();
        for (int i = 0; i < 60; i++) gq.push_back(20'($urandom));
        gen_cycle(1, 2, 30);
        k = 0;
        while (done !== 1'b1 && k < 3000) begin gen_cycle(0, 2, 30); k++; end
        chk("random_done", 32'(done), 1);

        // Router stalled: fill to full through the in-flight word
        do_reset();
        gq.push_back(20'h00010); gq.push_back(20'h001A3); gq.push_back(20'h00152);
        for (int i = 0; i < 9; i++) gq.push_back(20'($urandom));
        gen_cycle(1, 0, 0);
        k = 0;
        while (occupancy !== 4'd8 && k < 40) begin gen_cycle(0, 0, 0); k++; end
        repeat (3) gen_cycle(0, 0, 0);
        chk("full_occ", 32'(occupancy), 8);
        chk("full_gen_enable", 32'(gen_enable), 0);
        chk("full_drop", 32'(drop_cnt), 0);
        chk("full_head", 32'(flit_out), 32'h00010);

        // Forced writes while full and stalled are dropped
        for (int i = 0; i < 3; i++) step(0, 0, 1, 20'($urandom), 0);
        chk("drop3_cnt", 32'(drop_cnt), 3);
        chk("drop3_occ", 32'(occupancy), 8);
        chk("drop3_head", 32'(flit_out), 32'h00010);

        // Full with simultaneous push and pop
        step(0, 0, 1, 20'hABCDE, 1);
        chk("pushpop_occ", 32'(occupancy), 8);
        chk("pushpop_drop", 32'(drop_cnt), 3);
        chk("pushpop_head", 32'(flit_out), 32'h001A3);
        g_armed = 0;
        k = 0;
        while (done !== 1'b1 && k < 200) begin gen_cycle(0, 1, 0); k++; end
        chk("full_run_done", 32'(done), 1);
        chk("full_run_sent", 32'(sent_cnt), 13);

        // start in DONE is ignored
        step(0, 1, 0, 20'h0, 1);
        step(0, 0, 0, 20'h0, 1);
        chk("done_sticky", 32'(done), 1);

        // drop counter saturates in IDLE
        do_reset();
        for (int i = 0; i < DEPTH + 260; i++) step(0, 0, 1, 20'($urandom), 0);
        chk("drop_sat", 32'(drop_cnt), 255);
        chk("drop_sat_occ", 32'(occupancy), 8);

        // Reset mid-run with five stored flits
        do_reset();
        for (int i = 0; i < 5; i++) gq.push_back(20'($urandom));
        gen_cycle(1, 0, 0);
        k = 0;
        while (occupancy !== 4'd5 && k < 20) begin gen_cycle(0, 0, 0); k++; end
        chk("mid_occ5", 32'(occupancy), 5);
        chk("mid_gen_en", 32'(gen_enable), 1);
        step(1, 0, 1, 20'h12345, 1);
        gq.delete(); g_armed = 0; g_idle = 0;
        chk("mid_rst_occ", 32'(occupancy), 0);
        chk("mid_rst_valid", 32'(flit_valid), 0);
        chk("mid_rst_gen_en", 32'(gen_enable), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_sent", 32'(sent_cnt), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        step(0, 0, 0, 20'h0, 0);
        chk("mid_rst_idle", 32'(gen_enable), 0);
        step(0, 1, 0, 20'h0, 0);
        chk("mid_rst_restart", 32'(gen_enable), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inject_ni_buf.md
INJECT_NI_BUF -- requirements
Module: inject_ni_buf

Interface
REQ-001 Parameter: DEPTH, 8, number of FIFO entries (power of 2, >=4).
REQ-002 Parameter: IDLE_TO, 4, consecutive idle in_valid cycles in RUN that mark generator exhaustion.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  one-cycle pulse; begins an injection run.
REQ-006 Port: gen_enable  output  1  enable to the upstream stream generator (pauses it when low).
REQ-007 Port: in_data  input  20  flit from the generator.
REQ-008 Port: in_valid  input  1  in_data valid; no backpressure path upstream.
REQ-009 Port: flit_out  output  20  FIFO head flit to the router local port.
REQ-010 Port: flit_valid  output  1  flit_out valid.
REQ-011 Port: flit_ready  input  1  router accepts flit_out when flit_valid && flit_ready.
REQ-012 Port: dest_cluster  output  2  flit_out[3:2]; dest_local output 2 = flit_out[1:0].
REQ-013 Port: occupancy  output  log2(DEPTH)+1  stored entry count.
REQ-014 Port: sent_cnt  output  16  accepted-by-router flit count, wraps.
REQ-015 Port: drop_cnt  output  8  overflow drops, saturates at 255.
REQ-016 Port: done  output  1  high in DONE state.

Function
REQ-017 Flit format: [19:4] payload, [3:2] dest_cluster, [1:0] dest_local; the block does not modify flits.
REQ-018 FIFO: show-ahead; flit_out = head entry, flit_valid = (occupancy != 0), both purely from registered state.
REQ-019 Push when in_valid and (occupancy < DEPTH or pop this cycle); pop when flit_valid && flit_ready.
REQ-020 Simultaneous push+pop: occupancy unchanged; when full, push accepted.
REQ-021 Empty + push: no bypass; flit visible on flit_out the following cycle.
REQ-022 in_valid while full with no pop: flit discarded, drop_cnt +1 (saturating), FIFO contents unchanged.
REQ-023 While flit_valid && !flit_ready: flit_out stable.
REQ-024 Pointers wrap modulo DEPTH; FIFO order strictly preserved.
REQ-025 States: IDLE, RUN, DRAIN, DONE.
REQ-026 IDLE -> RUN on start; start ignored in RUN/DRAIN/DONE.
REQ-027 gen_enable = (state == RUN) && (occupancy <= DEPTH-2); combinational from registered state; absorbs the one-cycle in-flight word.
REQ-028 In RUN: idle counter clears on in_valid, counts cycles with gen_enable && !in_valid; cycles with gen_enable low neither count nor clear.
REQ-029 RUN -> DRAIN when idle counter reaches IDLE_TO.
REQ-030 In DRAIN: in_valid still pushed/dropped as in REQ-019..022; DRAIN -> DONE when occupancy == 0.
REQ-031 DONE is sticky until rst; done = 1 only in DONE; FIFO operations continue.
REQ-032 sent_cnt +1 per pop in any state, wraps at 16 bits.

Reset
REQ-033 rst high at a clock edge: state=IDLE, pointers=0, occupancy=0, idle counter=0, sent_cnt=0, drop_cnt=0.
REQ-034 Outputs during/after reset: gen_enable=0, flit_valid=0, done=0; flit_out/dest fields don't-care while flit_valid=0.
REQ-035 rst mid-run discards all stored flits; no pop occurs in the reset cycle.

Verification
REQ-036 Reset, start, flit_ready=1, generator streams 30 flits 0x00010..0x001E3 -> 30 flits out in order, sent_cnt=30, drop_cnt=0, done after drain.
REQ-037 flit_ready=0 throughout run -> occupancy reaches 8, gen_enable low at occupancy>=7, drop_cnt=0, flit_out stable at 0x00010.
REQ-038 Force in_valid high with generator bypassed, full, flit_ready=0 for 3 cycles -> drop_cnt=3, FIFO contents unchanged.
REQ-039 Full FIFO, in_valid=1 and flit_ready=1 same cycle -> occupancy stays 8, new flit stored, drop_cnt unchanged.
REQ-040 Head flit 0x001A3 -> dest_cluster=0, dest_local=3; 0x00152 -> dest_cluster=0, dest_local=2.
REQ-041 Assert rst with occupancy=5 in RUN -> next cycle occupancy=0, flit_valid=0, gen_enable=0, state IDLE, counters 0.
